pb_debounce: RTL and testbench
==============================

# pb_debounce

Input-conditioning stage for the Segway push-button and other slow asynchronous control inputs. It synchronizes a raw pin into the `clk` domain and debounces it with a counter-based state machine. It produces a clean level plus single-cycle rise and fall pulses. The pulses drive the enable or synchronous set/clear inputs of the downstream D-FF register stages.

## Interface
- `DEB_CYCLES`, default 16: consecutive stable synchronized samples required to accept a new level. Legal range is ≥1; elaboration error if 0.
- `clk` input, 1: system clock; every flop is posedge.
- `rst_n` input, 1: one clock; reset is asynchronous and active-low.
- `pb_raw` input, 1: raw asynchronous button/pin, active-high.
- `pb_level` output, 1: debounced level, registered.
- `pb_rise` output, 1: one-cycle pulse when `pb_level` goes 0→1, registered.
- `pb_fall` output, 1: one-cycle pulse when `pb_level` goes 1→0, registered.
- `glitch_cnt` output, 8: saturating count of rejected transitions. Present only with `PB_DEBOUNCE_GLITCH_CNT_EN`.

## Operation
- **Synchronizer:** two flops `s1 ← pb_raw`, `s2 ← s1`. The FSM reads `s2` only. Nothing else samples `pb_raw`.
- **Counter:** `cnt` is $clog2(DEB_CYCLES+1) bits wide. It is cleared on every state change and never wraps.
- **FSM states:** STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: if `s2`=1, go to WAIT_HI with `cnt`←0. Otherwise hold.
  - WAIT_HI, `s2`=1 and `cnt`==DEB_CYCLES-1: go to STABLE_HI, set `pb_level`←1 and `pb_rise`←1.
  - WAIT_HI, `s2`=1 otherwise: `cnt`←`cnt`+1.
  - WAIT_HI, `s2`=0: return to STABLE_LO. This is a glitch.
  - STABLE_HI, WAIT_LO: mirror images of the above, with `pb_level`←0 and `pb_fall`←1 on acceptance.
- **Outputs:** `pb_level` changes only on an accepting transition. It holds its value through WAIT_* states and glitches.
- **Pulses:** `pb_rise` and `pb_fall` are high for exactly one cycle, in the same cycle that `pb_level` first shows the new value. They are never high together.
- **Reset:** asynchronous assertion forces `s1`=`s2`=0, state STABLE_LO, `cnt`=0, `pb_level`=0, `pb_rise`=0, `pb_fall`=0, and `glitch_cnt`=0. This holds mid-WAIT; the partial count is discarded with no pulse.
- **After reset release:** if `pb_raw` is held at 1, the block treats it as a normal rise and emits `pb_rise` after the full latency.

## Timing
- Edge numbering: edge 0 is the first posedge sampling the new `pb_raw` value.
  - `s1` updates at edge 0.
  - `s2` updates at edge 1.
  - FSM enters WAIT_* at edge 2.
  - `pb_level` and the pulse update at edge 2+DEB_CYCLES.
- **Accept latency:** DEB_CYCLES+2 clocks from edge 0. With DEB_CYCLES=1 this is 3 clocks.
- **Rejection:** any `s2` sample opposite to the pending level during WAIT_* restarts qualification from the stable state.
  - A pulse on `pb_raw` shorter than DEB_CYCLES+1 clock periods never changes `pb_level`.
- **Minimum spacing:** two accepted transitions are at least DEB_CYCLES+1 cycles apart.
- **Combinational paths:** none from input to output.

## Configuration
- **Macro:** `PB_DEBOUNCE_GLITCH_CNT_EN`.
- **Defined:** the `glitch_cnt` port exists.
  - It increments by 1 on each WAIT_HI→STABLE_LO or WAIT_LO→STABLE_HI transition.
  - It saturates at 255 and does not wrap.
  - It is reset to 0 only by `rst_n`.
- **Undefined:** the port and its counter logic are absent. All other behaviour is identical.

## Test plan
All scenarios use DEB_CYCLES=4.
- **Reset values:** hold `rst_n`=0 with `pb_raw`=1. Required: `pb_level`=0, `pb_rise`=0, `pb_fall`=0, `glitch_cnt`=0. Release reset. Required: `pb_rise` is high for one cycle exactly 6 clocks after the first sampling edge, and `pb_level`=1 from then on.
- **Clean press and release:** set `pb_raw` 0→1 and hold 20 cycles. Required: `pb_level` rises at edge 6 with a single `pb_rise`. Then set `pb_raw` 1→0. Required: `pb_level` falls 6 edges later with a single `pb_fall`. `pb_rise` and `pb_fall` never overlap.
- **Bounce:** toggle `pb_raw` high 3 cycles, low 1, high 2, low 1, then high steadily. Required: exactly one `pb_rise`, 6 edges after the final rising sample. `glitch_cnt`=2.
- **Short pulse:** apply `pb_raw` high for 4 cycles, then low. Required: no `pb_rise`, `pb_level` stays 0, `glitch_cnt`=1.
- **Reset mid-qualification:** set `pb_raw`=1 and assert `rst_n`=0 asynchronously at edge 4, i.e. in WAIT_HI with `cnt`=2. Required: all outputs 0 immediately, with no clock edge needed. After release with `pb_raw` still 1, a full 6-cycle qualification produces one `pb_rise`.
- **Saturation** (macro on): inject 300 single-cycle glitches. Required: `glitch_cnt` stops at 255, and `pb_level` remains 0 throughout.

Source files
------------

// File: rtl/pb_debounce.sv
// Push-button synchronizer and counter-based debouncer with registered level and edge pulses.
// Optional saturating reject counter on glitch_cnt when PB_DEBOUNCE_GLITCH_CNT_EN is defined.
//
// state     | meaning
// ----------+--------------------------------------------------------
// STABLE_LO | accepted level 0, watching for a 1 on the synced input
// WAIT_HI   | qualifying a rise; cnt counts consecutive 1 samples
// STABLE_HI | accepted level 1, watching for a 0 on the synced input
// WAIT_LO   | qualifying a fall; cnt counts consecutive 0 samples
module pb_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pb_raw,
  output logic       pb_level,
  output logic       pb_rise,
  output logic       pb_fall
`ifdef PB_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  generate
    if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
      $error("pb_debounce: DEB_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_s1;
  logic            r_s2;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_level;
  logic            w_level_nxt;
  logic            r_rise;
  logic            w_rise_nxt;
  logic            r_fall;
  logic            w_fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= pb_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Any sample against the pending level drops back to the stable state and restarts.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      STABLE_LO: begin
        if (r_s2) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!r_s2) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!r_s2) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (r_s2) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign pb_level = r_level;
  assign pb_rise  = r_rise;
  assign pb_fall  = r_fall;

`ifdef PB_DEBOUNCE_GLITCH_CNT_EN
  logic       w_glitch;
  logic [7:0] r_glitch_cnt;

  assign w_glitch = ((r_state == WAIT_HI) && !r_s2) || ((r_state == WAIT_LO) && r_s2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch_cnt <= 8'd0;
    end else if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
      r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_pb_debounce.sv
// Directed bench for pb_debounce with DEB_CYCLES=4; expected values are hand-derived edge counts.
// Glitch-count checks and the saturation run are compiled only with PB_DEBOUNCE_GLITCH_CNT_EN.
module tb_pb_debounce;

  logic clk;
  logic rst_n;
  logic pb_raw;
  logic pb_level;
  logic pb_rise;
  logic pb_fall;
`ifdef PB_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int overlap = 0;
  int exp_glitch = 0;

  pb_debounce #(.DEB_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pb_raw    (pb_raw),
    .pb_level  (pb_level),
    .pb_rise   (pb_rise),
    .pb_fall   (pb_fall)
`ifdef PB_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (pb_rise) rise_cnt++;
      if (pb_fall) fall_cnt++;
      if (pb_rise && pb_fall) overlap++;
    end
  endtask

  task automatic clr_counts();
    rise_cnt = 0;
    fall_cnt = 0;
  endtask

  initial begin
    rst_n  = 1'b0;
    pb_raw = 1'b1;

    // reset values with pb_raw held high
    step(3);
    chk("rst_level", pb_level, 0);
    chk("rst_rise", pb_rise, 0);
    chk("rst_fall", pb_fall, 0);
`ifdef PB_DEBOUNCE_GLITCH_CNT_EN
    chk("rst_glitch", glitch_cnt, 0);
`endif
    clr_counts();
    rst_n = 1'b1;
    step(6);
    chk("rel_level_e5", pb_level, 0);
    chk("rel_rise_before", rise_cnt, 0);
    step(1);
    chk("rel_rise_e6", pb_rise, 1);
    chk("rel_level_e6", pb_level, 1);
    step(1);
    chk("rel_rise_e7", pb_rise, 0);
    chk("rel_level_e7", pb_level, 1);

    // clean press and release
    pb_raw = 1'b0;
    step(20);
    chk("idle_low_level", pb_level, 0);
    clr_counts();
    pb_raw = 1'b1;
    step(6);
    chk("press_level_e5", pb_level, 0);
    step(1);
    chk("press_rise_e6", pb_rise, 1);
    chk("press_level_e6", pb_level, 1);
    step(13);
    chk("press_rise_count", rise_cnt, 1);
    chk("press_fall_count", fall_cnt, 0);
    chk("press_level_hold", pb_level, 1);
    clr_counts();
    pb_raw = 1'b0;
    step(6);
    chk("release_level_e5", pb_level, 1);
    chk("release_fall_e5", pb_fall, 0);
    step(1);
    chk("release_fall_e6", pb_fall, 1);
    chk("release_level_e6", pb_level, 0);
    step(13);
    chk("release_fall_count", fall_cnt, 1);
    chk("release_rise_count", rise_cnt, 0);

    // bounce: high 3, low 1, high 2, low 1, then high
    clr_counts();
    pb_raw = 1'b1; step(3);
    pb_raw = 1'b0; step(1);
    pb_raw = 1'b1; step(2);
    pb_raw = 1'b0; step(1);
    pb_raw = 1'b1;
    exp_glitch += 2;
    step(6);
    chk("bounce_level_e5", pb_level, 0);
    chk("bounce_no_early_rise", rise_cnt, 0);
    step(1);
    chk("bounce_rise_e6", pb_rise, 1);
    chk("bounce_level_e6", pb_level, 1);
    step(10);
    chk("bounce_rise_count", rise_cnt, 1);
`ifdef PB_DEBOUNCE_GLITCH_CNT_EN
    chk("bounce_glitch", glitch_cnt, exp_glitch);
`endif
    pb_raw = 1'b0;
    step(20);
    chk("bounce_back_low", pb_level, 0);

    // short pulse of DEB_CYCLES cycles is rejected
    clr_counts();
    pb_raw = 1'b1; step(4);
    pb_raw = 1'b0; step(20);
    exp_glitch += 1;
    chk("short_rise_count", rise_cnt, 0);
    chk("short_level", pb_level, 0);
`ifdef PB_DEBOUNCE_GLITCH_CNT_EN
    chk("short_glitch", glitch_cnt, exp_glitch);
`endif

    // async reset at edge 4 (WAIT_HI, cnt=2)
    clr_counts();
    pb_raw = 1'b1;
    step(4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_glitch = 0;
    #1;
    chk("midrst_level", pb_level, 0);
    chk("midrst_rise", pb_rise, 0);
    chk("midrst_fall", pb_fall, 0);
`ifdef PB_DEBOUNCE_GLITCH_CNT_EN
    chk("midrst_glitch", glitch_cnt, exp_glitch);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(6);
    chk("midrst_no_early_rise", rise_cnt, 0);
    step(1);
    chk("midrst_rise_e6", pb_rise, 1);
    chk("midrst_level_e6", pb_level, 1);
    step(5);
    chk("midrst_rise_count", rise_cnt, 1);

`ifdef PB_DEBOUNCE_GLITCH_CNT_EN
    // saturation: 300 single-cycle glitches from a stable low level
    pb_raw = 1'b0;
    step(20);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step(2);
    clr_counts();
    for (int g = 0; g < 300; g++) begin
      pb_raw = 1'b1; step(1);
      pb_raw = 1'b0; step(1);
    end
    step(5);
    chk("sat_glitch", glitch_cnt, 255);
    chk("sat_rise_count", rise_cnt, 0);
    chk("sat_level", pb_level, 0);
`endif

    chk("no_rise_fall_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
